i2s_tx: RTL and testbench

//  Stereo I2S transmitter; sink of the FIR equalizer output path toward the DAC.
//  - Accepts 24-bit signed L/R sample pairs over a valid/ready handshake.
//  - Buffers one pair, generates BCLK/LRCK from clk, and serializes the data MSB-first in Philips I2S format.
//  - Flags underrun when no pair is ready at frame start.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_clkgen.sv | 68 ++++++
 rtl/i2s_tx.sv | 99 +++++++++
 tb/tb_i2s_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S transmit path.
// Samples are 24-bit two's complement, carried as left/right pairs.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W    = 24;
    localparam int unsigned I2S_SLOT_W    = 32;
    localparam int unsigned I2S_BCLK_HALF = 2;

    typedef logic signed [I2S_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCK generator: divides clk into BCLK and tracks the bit position within the frame.
// Fall events, frame start and slot bit index are combinational and valid in the clk that updates lrck.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned SLOT_W    = I2S_SLOT_W,
    parameter int unsigned BCLK_HALF = I2S_BCLK_HALF,
    localparam int unsigned DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1,
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_W),
    localparam int unsigned IDX_W    = $clog2(SLOT_W)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic             o_bclk,
    output logic             o_lrck,
    output logic             o_fall_evt,
    output logic             o_frame_start,
    output logic [IDX_W-1:0] o_slot_bit,
    output logic             o_slot_right
);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             r_lrck;
    logic [BIT_W-1:0] r_bit_cnt;

    logic             w_div_end;
    logic             w_fall;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_right;
    logic [IDX_W-1:0] w_slot_bit;

    always_comb begin
        w_div_end  = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
        w_fall     = w_div_end && r_bclk;
        w_bit_nxt  = (r_bit_cnt == BIT_W'(2 * SLOT_W - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
        w_right    = (w_bit_nxt >= BIT_W'(SLOT_W));
        w_slot_bit = w_right ? IDX_W'(w_bit_nxt - BIT_W'(SLOT_W)) : IDX_W'(w_bit_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b1;
            r_bit_cnt <= BIT_W'(2 * SLOT_W - 1);
        end else begin
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_right;
            end
        end
    end

    assign o_bclk        = r_bclk;
    assign o_lrck        = r_lrck;
    assign o_fall_evt    = w_fall;
    assign o_frame_start = w_fall && (w_bit_nxt == '0);
    assign o_slot_bit    = w_slot_bit;
    assign o_slot_right  = w_right;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-pair holding buffer, per-channel shift registers, Philips framing.
// A pair arriving in the fetch clk is held for the following frame, never bypassed.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W    = I2S_DATA_W,
    parameter int unsigned SLOT_W    = I2S_SLOT_W,
    parameter int unsigned BCLK_HALF = I2S_BCLK_HALF,
    localparam int unsigned IDX_W    = $clog2(SLOT_W)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_left,
    input  logic [DATA_W-1:0] i_s_right,
    output logic              o_i2s_bclk,
    output logic              o_i2s_lrck,
    output logic              o_i2s_sd,
    output logic              o_underrun
);

    logic              w_fall_evt;
    logic              w_frame_start;
    logic [IDX_W-1:0]  w_slot_bit;
    logic              w_slot_right;
    logic              w_xfer;
    logic              w_bit_on;

    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_sh_l;
    logic [DATA_W-1:0] r_sh_r;
    logic              r_sd;
    logic              r_underrun;

    i2s_clkgen #(
        .SLOT_W    (SLOT_W),
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_bclk        (o_i2s_bclk),
        .o_lrck        (o_i2s_lrck),
        .o_fall_evt    (w_fall_evt),
        .o_frame_start (w_frame_start),
        .o_slot_bit    (w_slot_bit),
        .o_slot_right  (w_slot_right)
    );

    always_comb begin
        w_xfer   = i_s_valid && !r_buf_full;
        // Slot bit 0 is the one-BCLK I2S delay; bits past DATA_W are padding zeros.
        w_bit_on = (w_slot_bit != '0) && (w_slot_bit <= IDX_W'(DATA_W));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_buf_full <= 1'b0;
            r_sh_l     <= '0;
            r_sh_r     <= '0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_buf_l <= i_s_left;
                r_buf_r <= i_s_right;
            end
            r_buf_full <= w_frame_start ? w_xfer : (r_buf_full | w_xfer);
            r_underrun <= w_frame_start && !r_buf_full;

            if (w_frame_start) begin
                r_sh_l <= r_buf_full ? r_buf_l : '0;
                r_sh_r <= r_buf_full ? r_buf_r : '0;
                r_sd   <= 1'b0;
            end else if (w_fall_evt) begin
                if (w_bit_on) begin
                    if (w_slot_right) begin
                        r_sd   <= r_sh_r[DATA_W-1];
                        r_sh_r <= {r_sh_r[DATA_W-2:0], 1'b0};
                    end else begin
                        r_sd   <= r_sh_l[DATA_W-1];
                        r_sh_l <= {r_sh_l[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    r_sd <= 1'b0;
                end
            end
        end
    end

    assign o_s_ready  = !r_buf_full;
    assign o_i2s_sd   = r_sd;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: randomized handshake traffic against a frame-level timing model,
// plus a DAC-side word capture for the directed pattern.
module tb_i2s_tx;

    localparam int DW   = 24;
    localparam int SW   = 32;
    localparam int HALF = 2;
    localparam int P    = 2 * HALF;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          i_clk;
    logic          i_reset;
    logic          i_s_valid;
    logic          o_s_ready;
    logic [DW-1:0] i_s_left;
    logic [DW-1:0] i_s_right;
    logic          o_i2s_bclk;
    logic          o_i2s_lrck;
    logic          o_i2s_sd;
    logic          o_underrun;

    i2s_tx dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_s_valid  (i_s_valid),
        .o_s_ready  (o_s_ready),
        .i_s_left   (i_s_left),
        .i_s_right  (i_s_right),
        .o_i2s_bclk (o_i2s_bclk),
        .o_i2s_lrck (o_i2s_lrck),
        .o_i2s_sd   (o_i2s_sd),
        .o_underrun (o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges since reset release, the buffered pair and the pair now playing.
    int unsigned   m_e;
    bit            m_full;
    logic [DW-1:0] m_buf_l, m_buf_r, m_cur_l, m_cur_r;
    bit            m_ur;
    pair_t         pq[$];
    int            prob;
    int            ur_cnt;

    // DAC-side capture on bclk rise
    logic          prev_bclk, prev_lrck;
    int            cap_cnt;
    logic [DW-1:0] cap_word, last_left, last_right;

    task automatic step(input bit rst);
        logic          v;
        logic [DW-1:0] l, r, w;
        bit            fetch, xfer;
        int            f, bc, b;
        bit            e_bclk, e_lrck, e_sd;

        v = 1'b0;
        l = DW'($urandom);
        r = DW'($urandom);
        if (!rst && pq.size() > 0 && $urandom_range(99) < prob) begin
            v = 1'b1;
            l = pq[0].l;
            r = pq[0].r;
        end
        i_reset   = rst;
        i_s_valid = v;
        i_s_left  = l;
        i_s_right = r;
        @(posedge i_clk);
        #1;

        if (rst) begin
            m_e = 0; m_full = 0; m_ur = 0; m_cur_l = '0; m_cur_r = '0; ur_cnt = 0;
        end else begin
            m_e++;
            fetch = (m_e % P == 0) && (((m_e / P) - 1) % (2 * SW) == 0);
            xfer  = v && !m_full;
            m_ur  = fetch && !m_full;
            if (fetch) begin
                m_cur_l = m_full ? m_buf_l : '0;
                m_cur_r = m_full ? m_buf_r : '0;
                m_full  = xfer;
            end else begin
                m_full = m_full | xfer;
            end
            if (xfer) begin
                m_buf_l = l;
                m_buf_r = r;
                void'(pq.pop_front());
            end
        end

        f      = m_e / P;
        bc     = (f == 0) ? (2 * SW - 1) : ((f - 1) % (2 * SW));
        b      = bc % SW;
        e_bclk = ((m_e / HALF) % 2) == 1;
        e_lrck = bc >= SW;
        w      = e_lrck ? m_cur_r : m_cur_l;
        e_sd   = (f != 0 && b >= 1 && b <= DW) ? w[DW-b] : 1'b0;

        check_eq("bclk", 32'(o_i2s_bclk), 32'(e_bclk));
        check_eq("lrck", 32'(o_i2s_lrck), 32'(e_lrck));
        check_eq("sd", 32'(o_i2s_sd), 32'(e_sd));
        check_eq("underrun", 32'(o_underrun), 32'(m_ur));
        check_eq("s_ready", 32'(o_s_ready), 32'(!m_full));

        if (o_underrun === 1'b1) ur_cnt++;
        if (rst) begin
            cap_cnt = 0;
        end else begin
            if (o_i2s_lrck !== prev_lrck) begin
                if (prev_lrck === 1'b0) last_left = cap_word;
                else last_right = cap_word;
                cap_cnt = 0;
            end
            if (o_i2s_bclk === 1'b1 && prev_bclk === 1'b0) begin
                if (cap_cnt >= 1 && cap_cnt <= DW) cap_word = {cap_word[DW-2:0], o_i2s_sd};
                cap_cnt++;
            end
        end
        prev_bclk = o_i2s_bclk;
        prev_lrck = o_i2s_lrck;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic do_reset(input int n);
        pq.delete();
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    initial begin
        pair_t p;
        prob = 100; cap_word = '0; last_left = '0; last_right = '0;
        prev_bclk = 1'b0; prev_lrck = 1'b1; cap_cnt = 0;

        // Reset values held over three clocks
        do_reset(3);

        // Directed pair before the first fetch, captured as the DAC would
        p.l = 24'hA50F3C; p.r = 24'h800001;
        pq.push_back(p);
        run(262);
        check_eq("dac_left", 32'(last_left), 32'h00A50F3C);
        check_eq("dac_right", 32'(last_right), 32'h00800001);

        // Idle stream: an underrun at each of the three fetches
        do_reset(1);
        run(520);
        check_eq("idle_underruns", 32'(ur_cnt), 32'd3);

        // Back-to-back pairs after the first fetch: no further underrun
        do_reset(1);
        run(10);
        for (int i = 0; i < 2; i++) begin
            p.l = DW'($urandom); p.r = DW'($urandom);
            pq.push_back(p);
        end
        run(520);
        check_eq("b2b_underruns", 32'(ur_cnt), 32'd1);

        // Valid rising exactly in the fetch clk
        do_reset(1);
        run(3);
        p.l = 24'h123456; p.r = 24'h7FFFFF;
        pq.push_back(p);
        run(520);

        // Reset at bit 10 of the left slot with a second pair buffered
        do_reset(1);
        p.l = DW'($urandom); p.r = DW'($urandom);
        pq.push_back(p);
        p.l = DW'($urandom); p.r = DW'($urandom);
        pq.push_back(p);
        run(44);
        do_reset(1);
        run(300);

        // Random traffic at varied offer rates
        for (int k = 0; k < 4; k++) begin
            do_reset(1);
            prob = 5 + 30 * k;
            for (int i = 0; i < 6; i++) begin
                p.l = DW'($urandom); p.r = DW'($urandom);
                pq.push_back(p);
            end
            run(3 * 256 + int'($urandom_range(60)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
